lcd_arbiter: RTL and testbench

LCD_ARBITER -- requirements
Module: lcd_arbiter

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/rr_picker.sv | 40 ++++
 rtl/lcd_arbiter.sv | 157 +++++++++++++++
 tb/tb_lcd_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants for the LCD arbiter: state encoding, line
//               width, blank-line value and default timing.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int LCD_LINE_W = 128;
    localparam int ID_W       = 3;

    localparam logic [7:0]            ASCII_SPACE = 8'h20;
    localparam logic [LCD_LINE_W-1:0] LINE_BLANK  = {(LCD_LINE_W / 8){ASCII_SPACE}};

    localparam int DEFAULT_NUM_REQ     = 4;
    localparam int DEFAULT_HOLD_CYCLES = 200;
    localparam int DEFAULT_BUSY_CYCLES = 250000;

    localparam logic [2:0] S_WAIT_INIT = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_GRANT     = 3'd2;
    localparam logic [2:0] S_REFRESH   = 3'd3;
    localparam logic [2:0] S_BUSY      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker; the first set request at or
//               after ptr (wrapping) wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import lcd_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    int w_dist;
    int w_best;

    // Smallest circular distance from ptr among the active requests wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        w_best   = NUM_REQ;
        w_dist   = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + NUM_REQ - int'(ptr));
            if (req[j] && (w_dist < w_best)) begin
                w_best   = w_dist;
                grant    = '0;
                grant[j] = 1'b1;
                grant_id = ID_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_arbiter
// Description : Shares one LCD controller between NUM_REQ requesters, one frame
//               at a time. Define LCD_ARB_URGENT_EN to give requester 0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int BUSY_CYCLES = DEFAULT_BUSY_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*LCD_LINE_W-1:0] req_line1,
    input  logic [NUM_REQ*LCD_LINE_W-1:0] req_line2,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy,
    output logic [ID_W-1:0]               cur_id,
    input  logic                          lcd_ready,
    output logic [LCD_LINE_W-1:0]         lcd_line1,
    output logic [LCD_LINE_W-1:0]         lcd_line2,
    output logic                          lcd_refresh
);

    localparam int c_CNT_W = $clog2(f_max(HOLD_CYCLES, BUSY_CYCLES) + 1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       w_ptr_nxt;
    logic [ID_W-1:0]       r_cur_id;
    logic [NUM_REQ-1:0]    r_ack;
    logic [NUM_REQ-1:0]    r_done;
    logic                  r_busy;
    logic                  r_refresh;
    logic [LCD_LINE_W-1:0] r_line1;
    logic [LCD_LINE_W-1:0] r_line2;

    logic [NUM_REQ-1:0]    w_pick_req;
    logic [NUM_REQ-1:0]    w_pick_grant;
    logic [ID_W-1:0]       w_pick_id;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_win_id;
    logic [LCD_LINE_W-1:0] w_sel_line1;
    logic [LCD_LINE_W-1:0] w_sel_line2;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .req      (w_pick_req),
        .ptr      (r_rr_ptr),
        .grant    (w_pick_grant),
        .grant_id (w_pick_id)
    );

`ifdef LCD_ARB_URGENT_EN
    assign w_pick_req = {req[NUM_REQ-1:1], 1'b0};
    assign w_grant    = req[0] ? NUM_REQ'(1) : w_pick_grant;
    assign w_win_id   = req[0] ? '0 : w_pick_id;
`else
    assign w_pick_req = req;
    assign w_grant    = w_pick_grant;
    assign w_win_id   = w_pick_id;
`endif

    always_comb begin
        w_sel_line1 = LINE_BLANK;
        w_sel_line2 = LINE_BLANK;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_win_id == ID_W'(j)) begin
                w_sel_line1 = req_line1[j*LCD_LINE_W +: LCD_LINE_W];
                w_sel_line2 = req_line2[j*LCD_LINE_W +: LCD_LINE_W];
            end
        end
    end

    always_comb begin
        w_ptr_nxt = (r_cur_id == ID_W'(NUM_REQ - 1)) ? '0 : r_cur_id + 1'b1;
`ifdef LCD_ARB_URGENT_EN
        if (r_cur_id == '0) begin
            w_ptr_nxt = r_rr_ptr;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_INIT: if (lcd_ready) w_state_nxt = S_IDLE;
            S_IDLE:      if (|req) w_state_nxt = S_GRANT;
            S_GRANT:     w_state_nxt = S_REFRESH;
            S_REFRESH:   if (r_cnt == c_CNT_W'(HOLD_CYCLES - 1)) w_state_nxt = S_BUSY;
            S_BUSY:      if (r_cnt == c_CNT_W'(BUSY_CYCLES - 1)) w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_WAIT_INIT;
        endcase
        // Losing the controller aborts whatever is in flight.
        if (!lcd_ready && (r_state != S_WAIT_INIT)) begin
            w_state_nxt = S_WAIT_INIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_WAIT_INIT;
            r_cnt     <= '0;
            r_rr_ptr  <= '0;
            r_cur_id  <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_refresh <= 1'b0;
            r_line1   <= LINE_BLANK;
            r_line2   <= LINE_BLANK;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_refresh <= (w_state_nxt == S_REFRESH);
            r_ack     <= '0;
            r_done    <= '0;

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_REFRESH) || (r_state == S_BUSY)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == S_IDLE) && (w_state_nxt == S_GRANT)) begin
                r_ack    <= w_grant;
                r_cur_id <= w_win_id;
                r_line1  <= w_sel_line1;
                r_line2  <= w_sel_line2;
            end

            if ((r_state == S_BUSY) && (w_state_nxt == S_DONE)) begin
                r_done   <= NUM_REQ'(1) << r_cur_id;
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign ack         = r_ack;
    assign done        = r_done;
    assign busy        = r_busy;
    assign cur_id      = r_cur_id;
    assign lcd_line1   = r_line1;
    assign lcd_line2   = r_line2;
    assign lcd_refresh = r_refresh;

endmodule
`default_nettype wire

// File: tb/tb_lcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_arbiter
// Description : Randomized bench for lcd_arbiter against a frame-timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 6;
    localparam int BUSY = 20;
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*128-1:0] req_line1;
    logic [N*128-1:0] req_line2;
    logic             lcd_ready;
    logic [N-1:0]     ack;
    logic [N-1:0]     done;
    logic             busy;
    logic [2:0]       cur_id;
    logic [127:0]     lcd_line1;
    logic [127:0]     lcd_line2;
    logic             lcd_refresh;

    lcd_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (HOLD),
        .BUSY_CYCLES (BUSY)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_line1   (req_line1),
        .req_line2   (req_line2),
        .ack         (ack),
        .done        (done),
        .busy        (busy),
        .cur_id      (cur_id),
        .lcd_ready   (lcd_ready),
        .lcd_line1   (lcd_line1),
        .lcd_line2   (lcd_line2),
        .lcd_refresh (lcd_refresh)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: frame timeline derived from the ack edge of the current frame.
    int           cyc;
    bit           m_init;
    bit           m_active;
    int           m_free_at;
    int           m_ack_edge;
    int           m_cur;
    int           m_ptr;
    logic [127:0] m_l1, m_l2;
    logic [N-1:0] e_ack, e_done;
    bit           e_ref, e_busy;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef LCD_ARB_URGENT_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_init = 1'b1; m_active = 1'b0; m_free_at = 0; m_ack_edge = -1000;
        m_cur = 0; m_ptr = 0; m_l1 = BLANK; m_l2 = BLANK;
    endtask

    task automatic model_edge();
        e_ack = '0;
        e_done = '0;
        if (m_init) begin
            if (lcd_ready) begin
                m_init = 1'b0;
                m_free_at = cyc + 1;
            end
        end else if (!lcd_ready) begin
            m_init = 1'b1;
            m_active = 1'b0;
        end else if (m_active) begin
            if (cyc == m_ack_edge + 1 + HOLD + BUSY) begin
                e_done[m_cur] = 1'b1;
                m_active = 1'b0;
                m_free_at = cyc + 2;
`ifdef LCD_ARB_URGENT_EN
                if (m_cur != 0) m_ptr = (m_cur + 1) % N;
`else
                m_ptr = (m_cur + 1) % N;
`endif
            end
        end else if (cyc >= m_free_at && req != '0) begin
            m_cur = pick(req, m_ptr);
            m_active = 1'b1;
            m_ack_edge = cyc;
            e_ack[m_cur] = 1'b1;
            m_l1 = req_line1[m_cur*128 +: 128];
            m_l2 = req_line2[m_cur*128 +: 128];
        end
        e_ref  = m_active && (cyc >= m_ack_edge + 1) && (cyc <= m_ack_edge + HOLD);
        e_busy = m_init || m_active || (cyc < m_free_at - 1);
    endtask

    task automatic rand_lines();
        for (int i = 0; i < N * 4; i++) begin
            req_line1[i*32 +: 32] = $urandom();
            req_line2[i*32 +: 32] = $urandom();
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check("ack", 128'(ack), 128'(e_ack));
        check("done", 128'(done), 128'(e_done));
        check("lcd_refresh", 128'(lcd_refresh), 128'(e_ref));
        check("busy", 128'(busy), 128'(e_busy));
        check("cur_id", 128'(cur_id), 128'(m_cur));
        check("lcd_line1", lcd_line1, m_l1);
        check("lcd_line2", lcd_line2, m_l2);
        rand_lines();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 128'(ack), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_cur_id"}, 128'(cur_id), 128'(0));
        check({tag, "_line1"}, lcd_line1, BLANK);
        check({tag, "_line2"}, lcd_line2, BLANK);
        check({tag, "_refresh"}, 128'(lcd_refresh), 128'(0));
    endtask

    initial begin
        int drop;
        bit reached;
        cyc = 0;
        model_reset();
        reset_n = 1'b0; lcd_ready = 1'b0; req = '0;
        req_line1 = '0; req_line2 = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Controller not ready: nobody may be granted.
        req = 4'b1111;
        repeat (1000) step();
        lcd_ready = 1'b1;

        // All requesting: strict rotation.
        repeat (6 * (HOLD + BUSY + 3)) step();

        // Single requester.
        req = 4'b0100;
        repeat (2 * (HOLD + BUSY + 3)) step();

        // Randomized traffic with occasional controller drop-outs.
        drop = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) req = N'($urandom());
            if (drop > 0) begin
                drop--;
                lcd_ready = (drop == 0);
            end else if ($urandom_range(299) == 0) begin
                drop = $urandom_range(8, 1);
                lcd_ready = 1'b0;
            end
            step();
        end
        lcd_ready = 1'b1;

        // Controller lost mid-BUSY: frame abandoned, same requester re-served.
        req = '0;
        repeat (HOLD + BUSY + 10) step();
        req = 4'b0010;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            step();
            reached = m_active && (cyc > m_ack_edge + HOLD + 5);
        end
        check("reach_busy", 128'(reached), 128'(1));
        lcd_ready = 1'b0;
        repeat (5) step();
        lcd_ready = 1'b1;
        repeat (HOLD + BUSY + 10) step();

        // Reset during REFRESH.
        req = 4'b1000;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            step();
            reached = e_ref;
        end
        check("reach_refresh", 128'(reached), 128'(1));
        step();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (3 * (HOLD + BUSY + 3)) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
